// File: rtl/bus_bridge_mux_if.sv
// Host-side request/response channel of the multiplexed-bus bridge.
// The master drives a word request; the slave (bridge) returns ready and read data.
interface bus_bridge_mux_if;
  logic        valid;
  logic        ready;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic [3:0]  wstrb;
  logic [31:0] dtr;

  modport master (output valid, rw, addr, dtw, wstrb, input ready, dtr);
  modport slave  (input valid, rw, addr, dtw, wstrb, output ready, dtr);
endinterface

// File: rtl/bus_bridge_mux.sv
// Bridge from a 32-bit word request to a narrow multiplexed address/data bus:
// per beat, NALE address-latch phases, a stretched data phase and a turnaround.
module bus_bridge_mux #(
  parameter int DW     = 16,
  parameter int AW     = 32,
  parameter int WAIT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_bridge_mux_if.slave      host,
  input  logic [WAIT_W-1:0]    cfg_wait,
  input  logic [DW-1:0]        bus_din,
  output logic [DW-1:0]        bus_dout,
  output logic                 bus_oe,
  output logic [AW/DW-1:0]     ale,
  output logic                 oe,
  output logic                 we,
  output logic [DW/8-1:0]      be,
  output logic                 busy
);
  localparam int NALE  = AW / DW;
  localparam int BEATS = 32 / DW;
  localparam int NBE   = DW / 8;
  localparam int PW    = (NALE > 1) ? $clog2(NALE) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TURN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             beat_q, beat_d, nb;
  logic [PW-1:0]          phase_q, phase_d;
  logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   rw_q, rw_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            dtw_q, dtw_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [31:0]            baddr_d;
  logic [DW-1:0]          addr_slice, wdat_slice;
  logic [NBE-1:0]         strb_slice;

  logic [BEATS-1:0][DW-1:0] dtr_q;
  logic [DW-1:0]          bus_dout_q;
  logic [NALE-1:0]        ale_q;
  logic [NBE-1:0]         be_q;
  logic                   bus_oe_q, oe_q, we_q, ready_q, busy_q;

  // Lowest beat at or after 'from' that needs bus cycles; BEATS means none left.
  function automatic logic [2:0] next_beat(input logic [2:0] from, input logic is_wr,
                                           input logic [3:0] strb);
    logic [2:0] r;
    r = 3'(BEATS);
    for (int b = BEATS - 1; b >= 0; b--)
      if (3'(b) >= from && (!is_wr || (|strb[b*NBE +: NBE])))
        r = 3'(b);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    wait_d  = wait_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    dtw_d   = dtw_q;
    wstrb_d = wstrb_q;
    nb      = 3'(BEATS);
    case (state_q)
      IDLE: if (host.valid) begin
        rw_d    = host.rw;
        addr_d  = host.addr;
        dtw_d   = host.dtw;
        wstrb_d = host.wstrb;
        wait_d  = cfg_wait;
        nb      = next_beat(3'd0, host.rw, host.wstrb);
        beat_d  = nb;
        phase_d = '0;
        state_d = (nb == 3'(BEATS)) ? DONE : ADDR;
      end
      ADDR: if (phase_q == PW'(NALE - 1)) begin
        state_d = DATA;
        wcnt_d  = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
      DATA: if (wcnt_q == wait_q) state_d = TURN;
            else wcnt_d = wcnt_q + 1'b1;
      TURN: begin
        nb = next_beat(beat_q + 3'd1, rw_q, wstrb_q);
        if (nb == 3'(BEATS)) begin
          state_d = DONE;
        end else begin
          state_d = ADDR;
          beat_d  = nb;
          phase_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-side values for the cycle being entered, so every output is a flop.
  assign baddr_d    = (addr_d & 32'hFFFF_FFFC) + 32'(beat_d) * 32'(NBE);
  assign addr_slice = DW'(baddr_d >> (int'(phase_d) * DW));
  assign wdat_slice = DW'(dtw_d >> (int'(beat_d) * DW));
  assign strb_slice = NBE'(wstrb_d >> (int'(beat_d) * NBE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      phase_q    <= '0;
      wcnt_q     <= '0;
      wait_q     <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      dtw_q      <= '0;
      wstrb_q    <= '0;
      dtr_q      <= '0;
      bus_dout_q <= '0;
      ale_q      <= '0;
      be_q       <= '0;
      bus_oe_q   <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      phase_q    <= phase_d;
      wcnt_q     <= wcnt_d;
      wait_q     <= wait_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      dtw_q      <= dtw_d;
      wstrb_q    <= wstrb_d;
      ale_q      <= (state_d == ADDR) ? (NALE'(1) << phase_d) : '0;
      bus_oe_q   <= (state_d == ADDR) || (state_d == DATA && rw_d);
      bus_dout_q <= (state_d == ADDR) ? addr_slice :
                    (state_d == DATA && rw_d) ? wdat_slice : '0;
      oe_q       <= (state_d == DATA) && !rw_d;
      we_q       <= (state_d == DATA) && rw_d;
      be_q       <= (state_d == DATA) ? (rw_d ? strb_slice : '1) : '0;
      ready_q    <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
      // Read data is taken only on the final cycle of the stretched data phase.
      for (int b = 0; b < BEATS; b++)
        if (state_q == DATA && !rw_q && wcnt_q == wait_q && beat_q == 3'(b))
          dtr_q[b] <= bus_din;
    end
  end

  assign host.ready = ready_q;
  assign host.dtr   = dtr_q;
  assign bus_dout   = bus_dout_q;
  assign bus_oe     = bus_oe_q;
  assign ale        = ale_q;
  assign oe         = oe_q;
  assign we         = we_q;
  assign be         = be_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_bus_bridge_mux.sv
// Directed plus random transactions against a cycle-trace model built from the bus rules.
module tb_bus_bridge_mux;
  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int WAIT_W = 4;
  localparam int NALE   = AW / DW;
  localparam int BEATS  = 32 / DW;
  localparam int NBE    = DW / 8;
  localparam int SW     = 5 + NALE + NBE;

  logic              clk = 1'b0;
  logic              reset;
  logic [WAIT_W-1:0] cfg_wait;
  logic [DW-1:0]     bus_din, bus_dout;
  logic              bus_oe, oe, we, busy;
  logic [NALE-1:0]   ale;
  logic [NBE-1:0]    be;

  bus_bridge_mux_if hif ();

  bus_bridge_mux #(.DW(DW), .AW(AW), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .host(hif), .cfg_wait(cfg_wait),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .ale(ale),
    .oe(oe), .we(we), .be(be), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_dtr;

  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] dout_q[$];
  logic [DW-1:0] din_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic rdy, input logic bsy, input logic [NALE-1:0] a,
                                       input logic o, input logic w, input logic [NBE-1:0] b,
                                       input logic boe);
    return {rdy, bsy, a, o, w, b, boe};
  endfunction

  function automatic logic [SW-1:0] obs_vec();
    return {hif.ready, busy, ale, oe, we, be, bus_oe};
  endfunction

  // At most one of ale/oe/we, and never drive the pads while reading.
  always @(negedge clk) if (mon_en)
    chk("excl", 64'(($countones({|ale, oe, we}) <= 1) && !(bus_oe && oe)), 64'd1);

  task automatic scramble();
    hif.rw    = 1'($urandom);
    hif.addr  = $urandom;
    hif.dtw   = $urandom;
    hif.wstrb = 4'($urandom);
    cfg_wait  = WAIT_W'($urandom);
  endtask

  task automatic run_txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdata, input logic [3:0] s,
                         input logic [WAIT_W-1:0] cw, input bit hold);
    logic [NBE-1:0] sl;
    logic [31:0]    baddr;
    exp_q.delete(); dout_q.delete(); din_q.delete();
    for (int b = 0; b < BEATS; b++) begin
      sl = NBE'(s >> (b * NBE));
      if (w && sl == '0) continue;
      baddr = {a[31:2], 2'b00} + 32'(b * NBE);
      for (int p = 0; p < NALE; p++) begin
        exp_q.push_back(mk(0, 1, NALE'(1) << p, 0, 0, '0, 1));
        dout_q.push_back(DW'(baddr >> (p * DW)));
        din_q.push_back(DW'($urandom));
      end
      for (int k = 0; k <= int'(cw); k++) begin
        exp_q.push_back(w ? mk(0, 1, '0, 0, 1, sl, 1) : mk(0, 1, '0, 1, 0, '1, 0));
        dout_q.push_back(DW'(d >> (b * DW)));
        din_q.push_back((k == int'(cw)) ? DW'(rdata >> (b * DW)) : DW'($urandom));
      end
      exp_q.push_back(mk(0, 1, '0, 0, 0, '0, 0));
      dout_q.push_back('0);
      din_q.push_back(DW'($urandom));
    end
    @(posedge clk); #1;
    chk({tag, "/idle"}, 64'({hif.ready, busy}), 64'd0);
    hif.valid = 1'b1; hif.rw = w; hif.addr = a; hif.dtw = d; hif.wstrb = s; cfg_wait = cw;
    @(posedge clk); #1;
    scramble();
    hif.valid = hold;
    for (int k = 0; k < exp_q.size(); k++) begin
      bus_din = din_q[k];
      chk($sformatf("%s/c%0d", tag, k + 1), 64'(obs_vec()), 64'(exp_q[k]));
      if (exp_q[k][0]) chk($sformatf("%s/dout%0d", tag, k + 1), 64'(bus_dout), 64'(dout_q[k]));
      @(posedge clk); #1;
    end
    chk($sformatf("%s/done@%0d", tag, exp_q.size() + 1), 64'(obs_vec()), 64'(mk(1, 1, '0, 0, 0, '0, 0)));
    if (!w) exp_dtr = rdata;
    chk({tag, "/dtr"}, 64'(hif.dtr), 64'(exp_dtr));
    $display("txn %s rw=%0d addr=%h wstrb=%b wait=%0d ready_at=%0d dtr=%h",
             tag, w, a, s, cw, exp_q.size() + 1, hif.dtr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; hif.valid = 1'b1; hif.rw = 1'b0; hif.addr = '0; hif.dtw = '0;
    hif.wstrb = '0; cfg_wait = '0; bus_din = '0; exp_dtr = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst/strobes", 64'(obs_vec()), 64'd0);
    chk("rst/dout", 64'(bus_dout), 64'd0);
    chk("rst/dtr", 64'(hif.dtr), 64'd0);
    reset = 1'b0; hif.valid = 1'b0;

    run_txn("rd100", 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0);
    run_txn("wr1100", 1, 32'h0000_0100, 32'h1234_5678, 32'h0, 4'b1100, 0, 0);
    run_txn("wr0000", 1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 4'b0000, 3, 0);
    run_txn("rdw2", 0, 32'h1234_5679, 32'h0, 32'h89AB_CDEF, 4'hF, 2, 0);
    run_txn("wr0110", 1, 32'h0000_0044, 32'hA1B2_C3D4, 32'h0, 4'b0110, 1, 0);
    run_txn("rdtop", 0, 32'hFFFF_FFFE, 32'h0, 32'h0BAD_F00D, 4'h0, 0, 0);
    run_txn("b2b0", 1, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 4'hF, 0, 1);
    run_txn("b2b1", 0, 32'h0000_0304, 32'h0, 32'h7777_1111, 4'hF, 0, 1);
    run_txn("b2b2", 1, 32'h0000_0308, 32'h0, 32'h0, 4'b0000, 0, 0);

    // Reset during the second data cycle of a write aborts it without a ready.
    @(posedge clk); #1;
    hif.valid = 1'b1; hif.rw = 1'b1; hif.addr = 32'h400; hif.dtw = 32'h1357_9BDF;
    hif.wstrb = 4'hF; cfg_wait = 2;
    @(posedge clk); #1;
    hif.valid = 1'b0;
    repeat (NALE + 1) @(posedge clk);
    #1;
    chk("abort/in_data", 64'(we), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_dtr = '0;
    chk("abort/strobes", 64'(obs_vec()), 64'd0);
    chk("abort/dtr", 64'(hif.dtr), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort/quiet%0d", k), 64'({hif.ready, busy}), 64'd0);
    end
    run_txn("after_abort", 0, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 4'hF, 1, 0);

    // Reset wins over a simultaneous request.
    @(posedge clk); #1;
    hif.valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio/busy", 64'(busy), 64'd0);
    hif.valid = 1'b0; reset = 1'b0;
    exp_dtr = '0;

    for (int i = 0; i < 24; i++)
      run_txn($sformatf("rnd%0d", i), 1'($urandom), $urandom, $urandom, $urandom,
              4'($urandom_range(0, 15)), WAIT_W'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
